// File: rtl/barrel_shift_ctrl.sv
// Round-robin arbiter and pass sequencer for a shared 4-bit logical barrel shifter.
// A job of any amount is split into passes of at most MAX_STEP positions.
module barrel_shift_ctrl #(
    parameter int DATA_W   = 4,
    parameter int AMT_W    = 4,
    parameter int MAX_STEP = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [DATA_W-1:0] req0_data,
    input  logic [AMT_W-1:0]  req0_amt,
    input  logic              req0_dir,
    input  logic [DATA_W-1:0] req1_data,
    input  logic [AMT_W-1:0]  req1_amt,
    input  logic              req1_dir,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_id,
    output logic [DATA_W-1:0] sh_data_in,
    output logic [1:0]        sh_shift_amt,
    output logic              sh_dir,
    input  logic [DATA_W-1:0] sh_data_out,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic [AMT_W-1:0] MAX_STEP_A = AMT_W'(MAX_STEP);

    state_e            state_q, state_d;
    logic              rr_ptr_q, rr_ptr_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [AMT_W-1:0]  rem_q, rem_d;
    logic              dir_q, dir_d;
    logic              id_q, id_d;

    logic [AMT_W-1:0]  step;
    logic              grant_id;
    logic [1:0]        grant;

    // Grants only while idle; on contention the pointer picks, otherwise the lone requester wins.
    always_comb begin
        grant    = 2'b00;
        grant_id = 1'b0;
        if (state_q == IDLE && !rst) begin
            grant_id = (req_valid == 2'b11) ? rr_ptr_q : req_valid[1];
            if (req_valid != 2'b00) begin
                grant = grant_id ? 2'b10 : 2'b01;
            end
        end
    end

    assign req_ready = grant;

    // NOTE: every variable gets a default before the case so no path leaves one unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        acc_d        = acc_q;
        rem_d        = rem_q;
        dir_d        = dir_q;
        id_d         = id_q;
        step         = (rem_q > MAX_STEP_A) ? MAX_STEP_A : rem_q;
        sh_data_in   = acc_q;
        sh_dir       = dir_q;
        sh_shift_amt = 2'b00;

        case (state_q)
            IDLE: begin
                if (grant != 2'b00) begin
                    rr_ptr_d = ~grant_id;
                    id_d     = grant_id;
                    acc_d    = grant_id ? req1_data : req0_data;
                    rem_d    = grant_id ? req1_amt  : req0_amt;
                    dir_d    = grant_id ? req1_dir  : req0_dir;
                    state_d  = (rem_d == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                sh_shift_amt = step[1:0];
                acc_d        = sh_data_out;
                rem_d        = rem_q - step;
                if (rem_q == step) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= 1'b0;
            acc_q    <= '0;
            rem_q    <= '0;
            dir_q    <= 1'b0;
            id_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            dir_q    <= dir_d;
            id_q     <= id_d;
        end
    end

    assign resp_valid = (state_q == DONE);
    assign resp_data  = acc_q;
    assign resp_id    = id_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_barrel_shift_ctrl.sv
// Scoreboard bench for barrel_shift_ctrl: a single driver issues directed and random jobs,
// a monitor predicts grants and results from the shift rules and compares each response.
module tb_barrel_shift_ctrl;

    localparam int DW = 4;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          v0, v1;
    logic [1:0]    req_valid;
    logic [1:0]    req_ready;
    logic [DW-1:0] req0_data, req1_data;
    logic [AW-1:0] req0_amt, req1_amt;
    logic          req0_dir, req1_dir;
    logic          resp_valid, resp_ready;
    logic [DW-1:0] resp_data;
    logic          resp_id;
    logic [DW-1:0] sh_data_in, sh_data_out;
    logic [1:0]    sh_shift_amt;
    logic          sh_dir;
    logic          busy;

    assign req_valid = {v1, v0};

    // Stand-in for the shared combinational shifter.
    assign sh_data_out = sh_dir ? (sh_data_in >> sh_shift_amt) : (sh_data_in << sh_shift_amt);

    barrel_shift_ctrl #(.DATA_W(DW), .AMT_W(AW), .MAX_STEP(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req0_data    (req0_data),
        .req0_amt     (req0_amt),
        .req0_dir     (req0_dir),
        .req1_data    (req1_data),
        .req1_amt     (req1_amt),
        .req1_dir     (req1_dir),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_data    (resp_data),
        .resp_id      (resp_id),
        .sh_data_in   (sh_data_in),
        .sh_shift_amt (sh_shift_amt),
        .sh_dir       (sh_dir),
        .sh_data_out  (sh_data_out),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int id;
        int amt;
        int result;
        int due;
        bit seen;
    } exp_t;

    exp_t sb[$];
    bit   model_busy = 1'b0;
    bit   model_rr   = 1'b0;
    int   shift_sum  = 0;
    int   vectors    = 0;
    int   miscompares = 0;
    int   grants[$];
    int   n_acc[2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int ref_shift(input int data, input int amt, input bit dir);
        if (dir) return data >> amt;
        return (data << amt) & ((1 << DW) - 1);
    endfunction

    // Monitor and scoreboard, sampled on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                sb.delete();
                model_busy = 1'b0;
                model_rr   = 1'b0;
                shift_sum  = 0;
            end else if (!model_busy) begin
                int         g;
                logic [1:0] want;
                check("busy_idle", busy, 0);
                check("resp_valid_idle", resp_valid, 0);
                check("sh_amt_idle", sh_shift_amt, 0);
                g    = (req_valid == 2'b11) ? int'(model_rr) : int'(req_valid[1]);
                want = (req_valid == 2'b00) ? 2'b00 : 2'(1 << g);
                check("req_ready", req_ready, want);
                if (req_valid != 2'b00) begin
                    e.id     = g;
                    e.amt    = (g == 1) ? int'(req1_amt) : int'(req0_amt);
                    e.result = (g == 1) ? ref_shift(int'(req1_data), e.amt, req1_dir)
                                        : ref_shift(int'(req0_data), e.amt, req0_dir);
                    e.due    = cyc + 1 + (e.amt + 2) / 3;
                    e.seen   = 1'b0;
                    sb.push_back(e);
                    model_rr   = (g == 0);
                    model_busy = 1'b1;
                    shift_sum  = 0;
                end
            end else begin
                check("busy", busy, 1);
                check("req_ready_busy", req_ready, 0);
                shift_sum += int'(sh_shift_amt);
                if (resp_valid) begin
                    if (!sb[0].seen) begin
                        check("latency", cyc, sb[0].due);
                        check("shift_total", shift_sum, sb[0].amt);
                        sb[0].seen = 1'b1;
                    end
                    check("resp_data", resp_data, sb[0].result);
                    check("resp_id", resp_id, sb[0].id);
                    if (resp_ready) begin
                        void'(sb.pop_front());
                        model_busy = 1'b0;
                    end
                end else if (sb[0].seen) begin
                    check("resp_hold", resp_valid, 1);
                end else if (cyc >= sb[0].due) begin
                    check("resp_late", resp_valid, 1);
                end
            end
        end
    end

    task automatic set_req(input int i, input logic [DW-1:0] d, input logic [AW-1:0] a,
                           input logic dir);
        if (i == 0) begin
            req0_data = d; req0_amt = a; req0_dir = dir; v0 = 1'b1;
        end else begin
            req1_data = d; req1_amt = a; req1_dir = dir; v1 = 1'b1;
        end
    endtask

    // Advance one cycle, retiring any request the controller accepted in it.
    task automatic step();
        bit t0, t1;
        @(negedge clk);
        t0 = v0 & req_ready[0];
        t1 = v1 & req_ready[1];
        @(posedge clk);
        #1;
        if (t0) begin v0 = 1'b0; n_acc[0]++; grants.push_back(0); end
        if (t1) begin v1 = 1'b0; n_acc[1]++; grants.push_back(1); end
    endtask

    task automatic drain(input int max_cycles);
        int n = 0;
        resp_ready = 1'b1;
        while ((v0 || v1 || sb.size() != 0 || model_busy) && n < max_cycles) begin
            step();
            n++;
        end
        check("drain_idle", int'(v0 || v1 || sb.size() != 0 || model_busy), 0);
    endtask

    initial begin
        rst = 1'b1; v0 = 1'b0; v1 = 1'b0; resp_ready = 1'b1;
        req0_data = '0; req0_amt = '0; req0_dir = 1'b0;
        req1_data = '0; req1_amt = '0; req1_dir = 1'b0;
        n_acc = '{0, 0};

        repeat (3) @(posedge clk);
        #1;
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_data", resp_data, 0);
        check("rst_resp_id", resp_id, 0);
        check("rst_busy", busy, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_sh_data_in", sh_data_in, 0);
        check("rst_sh_amt", sh_shift_amt, 0);
        check("rst_sh_dir", sh_dir, 0);
        rst = 1'b0;

        // Single pass, multi-pass, zero amount.
        set_req(0, 4'b1010, 4'd1, 1'b0);
        drain(50);
        set_req(1, 4'b1011, 4'd5, 1'b1);
        drain(50);
        set_req(0, 4'b1111, 4'd0, 1'b0);
        drain(50);

        // Backpressure: result held in DONE while another requester waits.
        resp_ready = 1'b0;
        set_req(0, 4'b0101, 4'd2, 1'b0);
        repeat (3) step();
        set_req(1, 4'b0011, 4'd3, 1'b1);
        repeat (7) step();
        drain(50);

        // Reset in the third SHIFT cycle of a 15-position job.
        set_req(0, 4'b1001, 4'd15, 1'b0);
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("midrst_busy", busy, 0);
        check("midrst_resp_valid", resp_valid, 0);
        @(posedge clk);
        #1;

        // Contention straight after reset: grants must alternate starting at 0.
        grants.delete();
        n_acc = '{0, 0};
        set_req(0, 4'b0110, 4'd2, 1'b0);
        set_req(1, 4'b0110, 4'd2, 1'b0);
        for (int k = 0; k < 200 && (n_acc[0] < 2 || n_acc[1] < 2); k++) begin
            step();
            if (!v0 && n_acc[0] < 2) set_req(0, 4'b0110, 4'd2, 1'b0);
            if (!v1 && n_acc[1] < 2) set_req(1, 4'b0110, 4'd2, 1'b0);
        end
        check("contention_grants", grants.size(), 4);
        for (int k = 0; k < grants.size() && k < 4; k++) begin
            check($sformatf("grant_order_%0d", k), grants[k], k % 2);
        end
        drain(50);

        // Random traffic with backpressure and occasional withdrawn requests.
        for (int k = 0; k < 400; k++) begin
            resp_ready = ($urandom_range(0, 3) != 0);
            if (!v0 && $urandom_range(0, 9) < 3)
                set_req(0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                        1'($urandom_range(0, 1)));
            else if (v0 && $urandom_range(0, 19) == 0)
                v0 = 1'b0;
            if (!v1 && $urandom_range(0, 9) < 3)
                set_req(1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                        1'($urandom_range(0, 1)));
            else if (v1 && $urandom_range(0, 19) == 0)
                v1 = 1'b0;
            step();
        end
        drain(200);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
